// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - instruction fetch controller: request FSM, IF buffer, skid entry, DE register
// Optional stall-cycle counter enabled by defining IF_STALL_CNT_EN.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_IF,
    input  logic        flush_DE,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst_IF,
    output logic        valid_IF,
    output logic [31:0] pc_DE,
    output logic [31:0] inst_DE,
    output logic        valid_DE,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t      r_state;
    logic [31:0] r_pc_fetch;
    logic        r_epoch;
    logic        r_req_epoch;
    logic [31:0] r_req_pc;
    logic        r_valid_IF;
    logic [31:0] r_pc_IF;
    logic [31:0] r_inst_IF;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_inst;
    logic [31:0] r_pc_DE;
    logic [31:0] r_inst_DE;
    logic        r_valid_DE;

    logic w_req_fire;
    logic w_rsp_fire;
    logic w_adv;
    logic w_de_load;

    // A redirect withdraws the request in the same cycle so it can never be accepted.
    assign imem_req_valid = (r_state == S_REQ) && !r_skid_valid && !br_taken;
    assign imem_req_addr  = r_pc_fetch;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_rsp_fire     = (r_state == S_WAIT) && imem_rsp_valid
                            && (r_req_epoch == r_epoch) && !br_taken;
    assign w_adv          = r_valid_IF && !stall_IF && !br_taken;
    assign w_de_load      = w_adv && !flush_DE;

    assign inst_IF  = r_valid_IF ? r_inst_IF : NOP_INST;
    assign valid_IF = r_valid_IF;
    assign pc_DE    = r_pc_DE;
    assign inst_DE  = r_inst_DE;
    assign valid_DE = r_valid_DE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_pc_fetch   <= RESET_PC;
            r_epoch      <= 1'b0;
            r_req_epoch  <= 1'b0;
            r_req_pc     <= 32'h0;
            r_valid_IF   <= 1'b0;
            r_pc_IF      <= 32'h0;
            r_inst_IF    <= NOP_INST;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'h0;
            r_skid_inst  <= NOP_INST;
            r_pc_DE      <= 32'h0;
            r_inst_DE    <= NOP_INST;
            r_valid_DE   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_REQ;
                S_REQ: begin
                    if (w_req_fire) begin
                        r_state     <= S_WAIT;
                        r_pc_fetch  <= r_pc_fetch + 32'd4;
                        r_req_pc    <= r_pc_fetch;
                        r_req_epoch <= r_epoch;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (br_taken) begin
                r_pc_fetch <= br_target;
                r_epoch    <= !r_epoch;
            end

            if (br_taken) begin
                r_valid_IF   <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_adv) begin
                if (r_skid_valid) begin
                    r_pc_IF      <= r_skid_pc;
                    r_inst_IF    <= r_skid_inst;
                    r_skid_valid <= w_rsp_fire;
                    r_skid_pc    <= r_req_pc;
                    r_skid_inst  <= imem_rsp_data;
                end else if (w_rsp_fire) begin
                    r_pc_IF   <= r_req_pc;
                    r_inst_IF <= imem_rsp_data;
                end else begin
                    r_valid_IF <= 1'b0;
                end
            end else if (w_rsp_fire) begin
                if (!r_valid_IF) begin
                    r_valid_IF <= 1'b1;
                    r_pc_IF    <= r_req_pc;
                    r_inst_IF  <= imem_rsp_data;
                end else begin
                    r_skid_valid <= 1'b1;
                    r_skid_pc    <= r_req_pc;
                    r_skid_inst  <= imem_rsp_data;
                end
            end

            // Bubbles keep pc_DE so the hazard unit still sees the last real PC.
            if (w_de_load) begin
                r_pc_DE    <= r_pc_IF;
                r_inst_DE  <= r_inst_IF;
                r_valid_DE <= 1'b1;
            end else begin
                r_inst_DE  <= NOP_INST;
                r_valid_DE <= 1'b0;
            end
        end
    end

`ifdef IF_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'h0;
        end else if (stall_IF && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - scoreboard bench for if_fetch_ctrl
module tb_if_fetch_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_STALL_CNT_EN
    localparam logic [31:0] EXP_CNT2 = 32'd2;
`else
    localparam logic [31:0] EXP_CNT2 = 32'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic        stall_IF;
    logic        flush_DE;
    logic        br_taken;
    logic [31:0] br_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst_IF;
    logic        valid_IF;
    logic [31:0] pc_DE;
    logic [31:0] inst_DE;
    logic        valid_DE;
    logic [31:0] stall_cnt;

    if_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_IF       (stall_IF),
        .flush_DE       (flush_DE),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_IF        (inst_IF),
        .valid_IF       (valid_IF),
        .pc_DE          (pc_DE),
        .inst_DE        (inst_DE),
        .valid_DE       (valid_DE),
        .stall_cnt      (stall_cnt)
    );

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_req_q[$];
    logic [31:0] exp_de_q[$];

    int          lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        mon_acc = 1'b0;
    logic [31:0] mon_addr = 32'h0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input bit to_de);
        exp_req_q.push_back(a);
        if (to_de) exp_de_q.push_back(a);
    endtask

    // Request monitor: records acceptance for the memory model and scores the address.
    always @(negedge clk) begin
        #2;
        mon_acc  = imem_req_valid && imem_req_ready;
        mon_addr = imem_req_addr;
        if (mon_acc) begin
            if (exp_req_q.size() == 0) begin
                chk("unexpected_req", mon_addr, 32'hFFFF_FFFF);
            end else begin
                chk("req_addr", mon_addr, exp_req_q.pop_front());
            end
        end
    end

    // DE monitor: every valid_DE cycle must match the next expected instruction.
    always @(negedge clk) begin
        logic [31:0] e;
        #2;
        if (valid_DE) begin
            if (exp_de_q.size() == 0) begin
                chk("unexpected_de", pc_DE, 32'hFFFF_FFFF);
            end else begin
                e = exp_de_q.pop_front();
                chk("de_pc", pc_DE, e);
                chk("de_inst", inst_DE, mem_data(e));
            end
        end
    end

    always @(posedge clk) begin
        logic acc;
        logic [31:0] a;
        acc = mon_acc;
        a   = mon_addr;
        #1;
        if (mem_cnt > 0) mem_cnt--;
        if (acc) begin
            mem_cnt  = lat;
            mem_addr = a;
        end
        imem_rsp_valid = (mem_cnt == 1);
        imem_rsp_data  = imem_rsp_valid ? mem_data(mem_addr) : 32'hDEAD_BEEF;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall_IF = 1'b0; flush_DE = 1'b0; br_taken = 1'b0;
        br_target = 32'h0; imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;

        push(32'h000, 1); push(32'h004, 1); push(32'h008, 1);
        push(32'h200, 1); push(32'h204, 1); push(32'h208, 1);
        push(32'h20C, 0); push(32'h100, 1);
        push(32'h104, 0); push(32'h000, 1);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid_IF", 32'(valid_IF), 32'd0);
        chk("rst_inst_IF", inst_IF, NOP);
        chk("rst_valid_DE", 32'(valid_DE), 32'd0);
        chk("rst_inst_DE", inst_DE, NOP);
        chk("rst_pc_DE", pc_DE, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);

        // Release and straight-line fetch of 0,4,8.
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("de_not_yet", 32'(valid_DE), 32'd0);
        @(negedge clk);
        chk("de_first_valid", 32'(valid_DE), 32'd1);
        chk("de_first_pc", pc_DE, 32'h0);
        repeat (2) @(negedge clk);
        imem_req_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Backpressure: address held; then redirect in the same cycle as ready.
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_addr", imem_req_addr, 32'h00C);
            chk("hold_valid", 32'(imem_req_valid), 32'd1);
            @(negedge clk);
        end
        imem_req_ready = 1'b1; br_taken = 1'b1; br_target = 32'h200;
        #1;
        chk("br_withdraw", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        br_taken = 1'b0;
        #1;
        chk("br_addr", imem_req_addr, 32'h200);

        // Load-use stall with bubble; response lands in the skid entry.
        repeat (4) @(negedge clk);
        stall_IF = 1'b1; flush_DE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("stall_inst_IF", inst_IF, mem_data(32'h204));
            chk("stall_valid_DE", 32'(valid_DE), 32'd0);
            chk("stall_inst_DE", inst_DE, NOP);
            chk("stall_pc_DE", pc_DE, 32'h200);
        end
        chk("skid_blocks_req", 32'(imem_req_valid), 32'd0);
        chk("stall_cnt_2", stall_cnt, EXP_CNT2);
        stall_IF = 1'b0; flush_DE = 1'b0;
        @(negedge clk);
        imem_req_ready = 1'b0;

        // Redirect while waiting on a slow response.
        repeat (2) @(negedge clk);
        lat = 3; imem_req_ready = 1'b1;
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h100;
        @(negedge clk);
        br_taken = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("redirect_addr", imem_req_addr, 32'h100);
        chk("redirect_valid", 32'(imem_req_valid), 32'd1);
        @(negedge clk);
        imem_req_ready = 1'b0;
        #1;
        chk("stale_dropped", 32'(valid_IF), 32'd0);
        repeat (6) @(negedge clk);

        // Reset while a response is outstanding.
        lat = 2; imem_req_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; imem_req_ready = 1'b0;
        #1;
        chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("arst_valid_IF", 32'(valid_IF), 32'd0);
        chk("arst_inst_DE", inst_DE, NOP);
        chk("arst_pc_DE", pc_DE, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rerun_addr", imem_req_addr, 32'h0);
        chk("rerun_valid_IF", 32'(valid_IF), 32'd0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        repeat (5) @(negedge clk);

        // Stall counter saturation (or constant zero without the counter).
`ifdef IF_STALL_CNT_EN
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
`endif
        stall_IF = 1'b1;
        @(negedge clk);
        #1;
`ifdef IF_STALL_CNT_EN
        chk("cnt_reach_max", stall_cnt, 32'hFFFF_FFFF);
`else
        chk("cnt_off_1", stall_cnt, 32'h0);
`endif
        repeat (2) @(negedge clk);
        #1;
`ifdef IF_STALL_CNT_EN
        chk("cnt_saturated", stall_cnt, 32'hFFFF_FFFF);
`else
        chk("cnt_off_3", stall_cnt, 32'h0);
`endif
        stall_IF = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        chk("req_q_drained", 32'(exp_req_q.size()), 32'd0);
        chk("de_q_drained", 32'(exp_de_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
